number_parser: RTL and testbench

- Downstream of the dictionary finder. When the finder reports a miss, this block re-reads the same TIB token from the memory block and converts it into a signed number for the data stack.
- It drives the shared memory block through the mb8_io master interface as read-only, one byte per cycle.
- It returns the parsed value, valid/error flags and the next TIB cursor.

---
 rtl/number_parser_if.sv | 11 +
 rtl/number_parser.sv | 212 +++++++++++++++++++++
 tb/tb_number_parser.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/number_parser_if.sv
// Byte-wide memory port shared by the finder and the number parser.
// The master drives the read address; the read byte returns separately on vw.
interface mb8_io #(
    parameter int unsigned ASZ = 17
) ();
    logic [ASZ-1:0] ai;
    logic           we;

    modport master (output ai, output we);
    modport slave  (input ai, input we);
endinterface

// File: rtl/number_parser.sv
// number_parser: re-reads a TIB token byte by byte after a dictionary miss and
// converts it into a signed NSZ-bit number. Accepts an optional '-' and '$'
// prefix in either order. Returns valid/error flags and the address just past
// the terminating delimiter (space or NUL).
// Optional overflow checking is enabled by defining NUMPARSE_OVF_EN; without it
// the accumulator wraps silently modulo 2^NSZ.
module number_parser #(
    parameter int unsigned DSZ = 8,
    parameter int unsigned ASZ = 17,
    parameter int unsigned NSZ = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mb8_io.master          mb_if,
    input  logic           en,
    input  logic [ASZ-1:0] aw,
    input  logic           hex,
    input  logic [DSZ-1:0] vw,
    output logic           bsy,
    output logic           vld,
    output logic           err,
    output logic [NSZ-1:0] num,
    output logic [ASZ-1:0] tib
);

    typedef enum logic [2:0] {StIdle, StPfx, StDig, StDone, StErr} state_e;

    localparam logic [7:0] ChMinus  = 8'h2D;
    localparam logic [7:0] ChDollar = 8'h24;
    localparam logic [7:0] ChSpace  = 8'h20;
    localparam logic [7:0] ChNul    = 8'h00;

`ifdef NUMPARSE_OVF_EN
    localparam int unsigned MW = NSZ + 5;
`else
    localparam int unsigned MW = NSZ;
`endif

    state_e         state_q, state_d;
    logic [ASZ-1:0] a1_q, a1_d;
    logic [NSZ-1:0] acc_q, acc_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic           dol_q, dol_d;
    logic           base16_q, base16_d;
    logic           bsy_q, bsy_d;
    logic           vld_q, vld_d;
    logic           err_q, err_d;
    logic [NSZ-1:0] num_q, num_d;
    logic [ASZ-1:0] tib_q, tib_d;

    logic [7:0]     byte_w;
    logic [4:0]     dig;
    logic           dig_ok;
    logic           is_delim;
    logic [MW-1:0]  mac;
    logic           ovf_step;
    logic           ovf_final;

    // Character to digit value; 31 marks a non-digit.
    function automatic logic [4:0] dig_val(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) begin
            return 5'(c - 8'h30);
        end else if (c >= 8'h41 && c <= 8'h46) begin
            return 5'(c - 8'h37);
        end else if (c >= 8'h61 && c <= 8'h66) begin
            return 5'(c - 8'h57);
        end else begin
            return 5'd31;
        end
    endfunction

    // Byte decode and multiply-accumulate datapath for the current byte.
    always_comb begin
        byte_w   = vw[7:0];
        dig      = dig_val(byte_w);
        dig_ok   = base16_q ? (dig < 5'd16) : (dig < 5'd10);
        is_delim = (byte_w == ChSpace) || (byte_w == ChNul);
        // x16 is a shift; x10 is x8 + x2.
        if (base16_q) begin
            mac = MW'({acc_q, 4'b0000}) + MW'(dig);
        end else begin
            mac = MW'({acc_q, 3'b000}) + MW'({acc_q, 1'b0}) + MW'(dig);
        end
`ifdef NUMPARSE_OVF_EN
        ovf_step  = |mac[MW-1:NSZ];
        // Negative range reaches one further than positive.
        ovf_final = neg_q ? (acc_q[NSZ-1] && (|acc_q[NSZ-2:0])) : acc_q[NSZ-1];
`else
        ovf_step  = 1'b0;
        ovf_final = 1'b0;
`endif
    end

    // Next-state, datapath update and memory address.
    always_comb begin
        state_d  = state_q;
        a1_d     = a1_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        dol_d    = dol_q;
        base16_d = base16_q;
        bsy_d    = bsy_q;
        vld_d    = vld_q;
        err_d    = err_q;
        num_d    = num_q;
        tib_d    = tib_q;
        mb_if.ai = (state_q == StIdle) ? aw : a1_q;
        mb_if.we = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    a1_d     = aw + ASZ'(1);
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = 1'b0;
                    dol_d    = 1'b0;
                    base16_d = hex;
                    bsy_d    = 1'b1;
                    vld_d    = 1'b0;
                    err_d    = 1'b0;
                    state_d  = StPfx;
                end
            end
            StPfx, StDig: begin
                if (!en) begin
                    bsy_d   = 1'b0;
                    state_d = StIdle;
                end else begin
                    a1_d = a1_q + ASZ'(1);
                    if (state_q == StPfx && byte_w == ChMinus && !neg_q) begin
                        neg_d = 1'b1;
                    end else if (state_q == StPfx && byte_w == ChDollar && !dol_q) begin
                        dol_d    = 1'b1;
                        base16_d = 1'b1;
                    end else if (is_delim) begin
                        if (cnt_q == 8'd0 || ovf_final) begin
                            err_d   = 1'b1;
                            bsy_d   = 1'b0;
                            state_d = StErr;
                        end else begin
                            num_d   = neg_q ? -acc_q : acc_q;
                            tib_d   = a1_q;
                            vld_d   = 1'b1;
                            bsy_d   = 1'b0;
                            state_d = StDone;
                        end
                    end else if (dig_ok && !ovf_step) begin
                        acc_d   = mac[NSZ-1:0];
                        // Saturate so very long tokens never read as empty.
                        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                        state_d = StDig;
                    end else begin
                        err_d   = 1'b1;
                        bsy_d   = 1'b0;
                        state_d = StErr;
                    end
                end
            end
            StDone, StErr: begin
                if (!en) begin
                    vld_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a1_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            dol_q    <= 1'b0;
            base16_q <= 1'b0;
            bsy_q    <= 1'b0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            num_q    <= '0;
            tib_q    <= '0;
        end else begin
            state_q  <= state_d;
            a1_q     <= a1_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            dol_q    <= dol_d;
            base16_q <= base16_d;
            bsy_q    <= bsy_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            num_q    <= num_d;
            tib_q    <= tib_d;
        end
    end

    assign bsy = bsy_q;
    assign vld = vld_q;
    assign err = err_q;
    assign num = num_q;
    assign tib = tib_q;

endmodule

// File: tb/tb_number_parser.sv
// Scoreboard bench for number_parser: each parse pushes its expected result,
// which is popped and compared when the block raises vld or err.
module tb_number_parser;

    localparam int unsigned ASZ = 17;
    localparam int unsigned DSZ = 8;
    localparam int unsigned NSZ = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           hex = 1'b0;
    logic [ASZ-1:0] aw = '0;
    logic [DSZ-1:0] vw = '0;
    logic           bsy;
    logic           vld;
    logic           err;
    logic [NSZ-1:0] num;
    logic [ASZ-1:0] tib;

    logic [7:0] mem [0:(1<<ASZ)-1];

    mb8_io #(.ASZ(ASZ)) mb_if ();

    number_parser #(.DSZ(DSZ), .ASZ(ASZ), .NSZ(NSZ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mb_if (mb_if),
        .en    (en),
        .aw    (aw),
        .hex   (hex),
        .vw    (vw),
        .bsy   (bsy),
        .vld   (vld),
        .err   (err),
        .num   (num),
        .tib   (tib)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory model.
    always @(posedge clk) vw <= mem[mb_if.ai];

    typedef struct {
        logic           v;
        logic           e;
        logic [NSZ-1:0] n;
        logic [ASZ-1:0] t;
        int             lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic v, input logic e, input logic [NSZ-1:0] n,
                                input logic [ASZ-1:0] t, input int lat);
        exp_t x;
        x.v = v;
        x.e = e;
        x.n = n;
        x.t = t;
        x.lat = lat;
        return x;
    endfunction

    task automatic load(input logic [ASZ-1:0] a, input string tok, input logic [7:0] dl);
        for (int i = 0; i < tok.len(); i++) mem[32'(a) + i] = tok[i];
        mem[32'(a) + tok.len()] = dl;
    endtask

    task automatic parse(input string tag, input logic [ASZ-1:0] a, input logic h,
                         input string tok, input logic [7:0] dl, input exp_t e);
        exp_t x;
        int   lat;
        load(a, tok, dl);
        sb_q.push_back(e);
        @(negedge clk);
        aw  = a;
        hex = h;
        en  = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!(vld || err) && lat < 64);
        x = sb_q.pop_front();
        if (lat >= 64) check({tag, ".timeout"}, 64'(lat), 64'(x.lat));
        check({tag, ".lat"}, 64'(lat), 64'(x.lat));
        check({tag, ".vld"}, 64'(vld), 64'(x.v));
        check({tag, ".err"}, 64'(err), 64'(x.e));
        check({tag, ".num"}, 64'(num), 64'(x.n));
        check({tag, ".tib"}, 64'(tib), 64'(x.t));
        check({tag, ".bsy"}, 64'(bsy), 64'(0));
        // Result holds while en stays high.
        @(posedge clk);
        @(negedge clk);
        check({tag, ".hold"}, 64'({vld, err}), 64'({x.v, x.e}));
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, ".clr"}, 64'({vld, err, bsy}), 64'(0));
        check({tag, ".keep"}, 64'({num, tib}), 64'({x.n, x.t}));
        check({tag, ".idle_ai"}, 64'(mb_if.ai), 64'(a));
    endtask

    logic [NSZ-1:0] last_n;
    logic [ASZ-1:0] last_t;

    initial begin
        #12;
        check("rst.outs", 64'({bsy, vld, err}), 64'(0));
        check("rst.num", 64'(num), 64'(0));
        check("rst.tib", 64'(tib), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        parse("dec123", 17'h100, 1'b0, "123", 8'h20, mk(1, 0, 32'd123, 17'h104, 4));
        parse("neg_hex", 17'h200, 1'b0, "-$1F", 8'h00, mk(1, 0, 32'hFFFF_FFE1, 17'h205, 5));
        parse("hex_ff", 17'h300, 1'b1, "ff", 8'h20, mk(1, 0, 32'd255, 17'h303, 3));
        parse("dec_ff", 17'h300, 1'b0, "ff", 8'h20, mk(0, 1, 32'd255, 17'h303, 1));
        parse("minus", 17'h400, 1'b0, "-", 8'h20, mk(0, 1, 32'd255, 17'h303, 2));
        parse("bad_g", 17'h500, 1'b0, "12G4", 8'h20, mk(0, 1, 32'd255, 17'h303, 3));
        parse("dol_neg", 17'h700, 1'b0, "$-7", 8'h20, mk(1, 0, 32'hFFFF_FFF9, 17'h704, 4));
        parse("dbl_neg", 17'h780, 1'b0, "--5", 8'h20, mk(0, 1, 32'hFFFF_FFF9, 17'h704, 2));
`ifdef NUMPARSE_OVF_EN
        parse("big", 17'h600, 1'b0, "4294967296", 8'h20,
              mk(0, 1, 32'hFFFF_FFF9, 17'h704, 10));
        last_n = 32'hFFFF_FFF9;
        last_t = 17'h704;
`else
        parse("big", 17'h600, 1'b0, "4294967296", 8'h20, mk(1, 0, 32'd0, 17'h60B, 11));
        last_n = 32'd0;
        last_t = 17'h60B;
`endif

        // Abort after two bytes.
        load(17'h800, "98765", 8'h20);
        @(negedge clk);
        aw = 17'h800;
        hex = 1'b0;
        en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort.bsy_before", 64'(bsy), 64'(1));
        en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort.outs", 64'({bsy, vld, err}), 64'(0));
        check("abort.keep", 64'({num, tib}), 64'({last_n, last_t}));
        check("abort.idle_ai", 64'(mb_if.ai), 64'(17'h800));

        // Asynchronous reset mid-parse.
        @(negedge clk);
        aw = 17'h100;
        en = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.outs", 64'({bsy, vld, err}), 64'(0));
        check("arst.num", 64'(num), 64'(0));
        check("arst.tib", 64'(tib), 64'(0));
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
